// File: rtl/module_frame_decoder_pkg.sv
// Shared constants, frame field positions and helpers for the module-side
// sine command frame decoder.
package module_frame_decoder_pkg;

    localparam logic [3:0] BROADCAST_ID         = 4'hF;
    localparam int         BYTE_TIMEOUT_DEFAULT = 32'sd720;
    localparam int         NUM_OF_MODULES       = 32'sd8;

    // Low byte layout: {index[3:0], id[3:0]}; the high byte is index[11:4].
    localparam int IDX_LO_MSB = 32'sd7;
    localparam int IDX_LO_LSB = 32'sd4;
    localparam int ID_MSB     = 32'sd3;
    localparam int ID_LSB     = 32'sd0;

    typedef enum logic [0:0] {
        WAIT_HI = 1'b0,
        WAIT_LO = 1'b1
    } dec_state_t;

    function automatic logic [3:0] frame_lo_index(input logic [7:0] lo_byte);
        return lo_byte[IDX_LO_MSB:IDX_LO_LSB];
    endfunction

    function automatic logic [3:0] frame_id(input logic [7:0] lo_byte);
        return lo_byte[ID_MSB:ID_LSB];
    endfunction

    function automatic logic [7:0] sat_add8(input logic [7:0] base, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, base} + {7'b0000000, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/module_frame_decoder_sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge pulse, for
// external asynchronous strobes such as the shoot line.
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic pulse
);

    logic meta_r;
    logic sync_r;
    logic prev_r;
    logic pulse_r;

    // Synchronizer chain and one-cycle rising-edge pulse register.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_r  <= 1'b0;
            sync_r  <= 1'b0;
            prev_r  <= 1'b0;
            pulse_r <= 1'b0;
        end else begin
            meta_r  <= async_in;
            sync_r  <= meta_r;
            prev_r  <= sync_r;
            pulse_r <= sync_r & ~prev_r;
        end
    end

    assign pulse = pulse_r;

endmodule

// File: rtl/module_frame_decoder.sv
// Receives the two-byte sine command frame, stages the index for this module
// and commits it to the gate-drive side on each synchronized shoot edge.
module module_frame_decoder
    import module_frame_decoder_pkg::*;
#(
    parameter logic [3:0] MODULE_ID    = 4'h1,
    parameter int         BYTE_TIMEOUT = BYTE_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_done,
    input  logic [7:0]  rx_data,
    input  logic        parity_error,
    input  logic        shoot,
    output logic [11:0] staged_index,
    output logic [3:0]  staged_id,
    output logic        frame_valid,
    output logic [11:0] active_index,
    output logic        active_valid,
    output logic        frame_error,
    output logic [7:0]  err_count
);

    localparam int TW = $clog2(BYTE_TIMEOUT + 32'sd1);
    localparam logic [TW-1:0] TMO_LAST = TW'(BYTE_TIMEOUT - 32'sd1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(32'sd1);
    localparam logic [TW-1:0] TMO_ZERO = TW'(32'sd0);

    dec_state_t    state_r;
    dec_state_t    state_s;
    logic [7:0]    hi_r;
    logic [7:0]    hi_s;
    logic [TW-1:0] tmo_cnt_r;
    logic [TW-1:0] tmo_cnt_s;

    logic          accept_s;
    logic          parity_err_s;
    logic          timeout_s;
    logic          missed_s;
    logic [1:0]    err_inc_s;
    logic [3:0]    rx_id_s;
    logic          id_match_s;
    logic          shoot_pulse_s;

    logic [11:0]   staged_index_r;
    logic [3:0]    staged_id_r;
    logic          frame_valid_r;
    logic [11:0]   active_index_r;
    logic          active_valid_r;
    logic          frame_error_r;
    logic [7:0]    err_count_r;
    logic          pending_r;

    sync_edge u_shoot_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (shoot),
        .pulse    (shoot_pulse_s)
    );

    // Frame FSM state, held high byte and inter-byte timeout counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= WAIT_HI;
            hi_r      <= 8'h00;
            tmo_cnt_r <= TMO_ZERO;
        end else begin
            state_r   <= state_s;
            hi_r      <= hi_s;
            tmo_cnt_r <= tmo_cnt_s;
        end
    end

    // Next-state logic and per-cycle frame events.
    always_comb begin
        state_s      = state_r;
        hi_s         = hi_r;
        tmo_cnt_s    = tmo_cnt_r;
        accept_s     = 1'b0;
        parity_err_s = 1'b0;
        timeout_s    = 1'b0;
        rx_id_s      = frame_id(rx_data);
        id_match_s   = (rx_id_s == MODULE_ID) || (rx_id_s == BROADCAST_ID);
        case (state_r)
            WAIT_HI: begin
                if (rx_done && parity_error) begin
                    parity_err_s = 1'b1;
                end else if (rx_done) begin
                    hi_s      = rx_data;
                    tmo_cnt_s = TMO_ZERO;
                    state_s   = WAIT_LO;
                end else begin
                    state_s = WAIT_HI;
                end
            end
            WAIT_LO: begin
                // A byte arriving on the timeout cycle takes precedence.
                if (rx_done && parity_error) begin
                    parity_err_s = 1'b1;
                    hi_s         = 8'h00;
                    state_s      = WAIT_HI;
                end else if (rx_done) begin
                    accept_s = id_match_s;
                    state_s  = WAIT_HI;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    timeout_s = 1'b1;
                    state_s   = WAIT_HI;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + TMO_ONE;
                end
            end
            default: begin
                state_s = WAIT_HI;
            end
        endcase
        missed_s  = shoot_pulse_s & ~pending_r;
        err_inc_s = {1'b0, parity_err_s | timeout_s} + {1'b0, missed_s};
    end

    // Staging, shoot commit, pending flag and error reporting.
    always_ff @(posedge clk) begin
        if (reset) begin
            staged_index_r <= 12'h000;
            staged_id_r    <= 4'h0;
            frame_valid_r  <= 1'b0;
            active_index_r <= 12'h000;
            active_valid_r <= 1'b0;
            frame_error_r  <= 1'b0;
            err_count_r    <= 8'h00;
            pending_r      <= 1'b0;
        end else begin
            frame_valid_r <= accept_s;
            if (accept_s) begin
                staged_index_r <= {hi_r, frame_lo_index(rx_data)};
                staged_id_r    <= frame_id(rx_data);
            end
            // Commit samples the pre-update staged value on a coincident frame.
            if (shoot_pulse_s) begin
                active_index_r <= staged_index_r;
                active_valid_r <= 1'b1;
            end
            if (accept_s) begin
                pending_r <= 1'b1;
            end else if (shoot_pulse_s) begin
                pending_r <= 1'b0;
            end
            frame_error_r <= (err_inc_s != 2'b00);
            err_count_r   <= sat_add8(err_count_r, err_inc_s);
        end
    end

    assign staged_index = staged_index_r;
    assign staged_id    = staged_id_r;
    assign frame_valid  = frame_valid_r;
    assign active_index = active_index_r;
    assign active_valid = active_valid_r;
    assign frame_error  = frame_error_r;
    assign err_count    = err_count_r;

endmodule

// File: tb/tb_module_frame_decoder.sv
// Directed bench for module_frame_decoder: frame staging, ID filtering,
// timeout, parity, shoot commit timing, error counting and reset.
module tb_module_frame_decoder;

    logic        clk;
    logic        reset;
    logic        rx_done;
    logic [7:0]  rx_data;
    logic        parity_error;
    logic        shoot;
    logic [11:0] staged_index;
    logic [3:0]  staged_id;
    logic        frame_valid;
    logic [11:0] active_index;
    logic        active_valid;
    logic        frame_error;
    logic [7:0]  err_count;

    int vectors;
    int miscompares;
    int fv_cnt;
    int fe_cnt;
    int fv_snap;
    int fe_snap;

    module_frame_decoder #(
        .MODULE_ID    (4'h1),
        .BYTE_TIMEOUT (720)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done      (rx_done),
        .rx_data      (rx_data),
        .parity_error (parity_error),
        .shoot        (shoot),
        .staged_index (staged_index),
        .staged_id    (staged_id),
        .frame_valid  (frame_valid),
        .active_index (active_index),
        .active_valid (active_valid),
        .frame_error  (frame_error),
        .err_count    (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters for frame_valid and frame_error.
    always @(posedge clk) begin
        if (frame_valid) fv_cnt <= fv_cnt + 1;
        if (frame_error) fe_cnt <= fe_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic pe);
        rx_done      = 1'b1;
        rx_data      = d;
        parity_error = pe;
        tick();
        rx_done      = 1'b0;
        parity_error = 1'b0;
        rx_data      = 8'h00;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        fv_snap = fv_cnt;
        fe_snap = fe_cnt;
    endtask

    initial begin
        vectors = 0; miscompares = 0; fv_cnt = 0; fe_cnt = 0;
        reset = 1'b1; rx_done = 1'b0; rx_data = 8'h00; parity_error = 1'b0; shoot = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_staged_index", 32'(staged_index), 32'h000);
        chk("rst_staged_id", 32'(staged_id), 32'h0);
        chk("rst_active_valid", 32'(active_valid), 32'h0);
        chk("rst_err_count", 32'(err_count), 32'h00);
        chk("rst_frame_valid", 32'(frame_valid), 32'h0);

        // Basic frame, 10 cycles between bytes
        snap();
        send_byte(8'hAB, 1'b0);
        repeat (9) tick();
        send_byte(8'hC1, 1'b0);
        chk("basic_frame_valid", 32'(frame_valid), 32'h1);
        chk("basic_index", 32'(staged_index), 32'hABC);
        chk("basic_id", 32'(staged_id), 32'h1);
        tick();
        chk("basic_fv_pulse", 32'(frame_valid), 32'h0);
        chk("basic_fv_count", 32'(fv_cnt - fv_snap), 32'd1);
        chk("basic_err_count", 32'(err_count), 32'h00);

        // Foreign ID dropped silently, broadcast accepted
        snap();
        send_byte(8'hAB, 1'b0);
        send_byte(8'hC5, 1'b0);
        tick();
        chk("foreign_fv_count", 32'(fv_cnt - fv_snap), 32'd0);
        chk("foreign_fe_count", 32'(fe_cnt - fe_snap), 32'd0);
        chk("foreign_id_kept", 32'(staged_id), 32'h1);
        send_byte(8'hAB, 1'b0);
        send_byte(8'hCF, 1'b0);
        chk("bcast_frame_valid", 32'(frame_valid), 32'h1);
        chk("bcast_id", 32'(staged_id), 32'hF);
        chk("bcast_index", 32'(staged_index), 32'hABC);

        // Low byte on the timeout cycle wins
        send_byte(8'h9D, 1'b0);
        repeat (719) tick();
        send_byte(8'h2F, 1'b0);
        chk("tmo_edge_fv", 32'(frame_valid), 32'h1);
        chk("tmo_edge_no_err", 32'(frame_error), 32'h0);
        chk("tmo_edge_index", 32'(staged_index), 32'h9D2);

        // Real timeout
        send_byte(8'hAA, 1'b0);
        repeat (719) tick();
        chk("tmo_not_yet", 32'(frame_error), 32'h0);
        tick();
        chk("tmo_error", 32'(frame_error), 32'h1);
        chk("tmo_err_count", 32'(err_count), 32'd1);
        tick();
        chk("tmo_pulse_end", 32'(frame_error), 32'h0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h31, 1'b0);
        chk("after_tmo_index", 32'(staged_index), 32'h123);
        chk("after_tmo_id", 32'(staged_id), 32'h1);

        // Parity on high byte, then good pair
        snap();
        send_byte(8'h77, 1'b1);
        chk("par_hi_error", 32'(frame_error), 32'h1);
        send_byte(8'h55, 1'b0);
        send_byte(8'h61, 1'b0);
        chk("par_hi_index", 32'(staged_index), 32'h556);
        chk("par_hi_fe_count", 32'(fe_cnt - fe_snap), 32'd1);
        chk("par_hi_err_count", 32'(err_count), 32'd2);
        // Parity on low byte discards the frame
        send_byte(8'h44, 1'b0);
        send_byte(8'h91, 1'b1);
        chk("par_lo_error", 32'(frame_error), 32'h1);
        chk("par_lo_index_kept", 32'(staged_index), 32'h556);
        chk("par_lo_err_count", 32'(err_count), 32'd3);

        // Shoot commit latency
        send_byte(8'h7E, 1'b0);
        send_byte(8'h41, 1'b0);
        chk("pre_shoot_active", 32'(active_index), 32'h000);
        shoot = 1'b1;
        repeat (3) tick();
        chk("shoot_m2_active", 32'(active_index), 32'h000);
        chk("shoot_m2_valid", 32'(active_valid), 32'h0);
        tick();
        chk("shoot_m3_active", 32'(active_index), 32'h7E4);
        chk("shoot_m3_valid", 32'(active_valid), 32'h1);
        chk("shoot_m3_no_err", 32'(frame_error), 32'h0);
        shoot = 1'b0;
        repeat (4) tick();

        // Shoot without new frame: missed-frame error
        shoot = 1'b1;
        repeat (4) tick();
        chk("missed_active_kept", 32'(active_index), 32'h7E4);
        chk("missed_error", 32'(frame_error), 32'h1);
        chk("missed_err_count", 32'(err_count), 32'd4);
        shoot = 1'b0;
        repeat (4) tick();

        // Commit coincident with staging takes the previous value
        send_byte(8'h3C, 1'b0);
        send_byte(8'h51, 1'b0);
        send_byte(8'h6A, 1'b0);
        shoot = 1'b1;
        repeat (3) tick();
        send_byte(8'h71, 1'b0);
        chk("coinc_active", 32'(active_index), 32'h3C5);
        chk("coinc_staged", 32'(staged_index), 32'h6A7);
        chk("coinc_no_err", 32'(frame_error), 32'h0);
        shoot = 1'b0;
        repeat (4) tick();
        shoot = 1'b1;
        repeat (4) tick();
        chk("coinc_pending_active", 32'(active_index), 32'h6A7);
        chk("coinc_pending_no_err", 32'(frame_error), 32'h0);
        chk("coinc_err_count", 32'(err_count), 32'd4);
        shoot = 1'b0;
        repeat (4) tick();

        // Parity and missed frame on the same cycle
        snap();
        shoot = 1'b1;
        repeat (3) tick();
        send_byte(8'h00, 1'b1);
        chk("double_error", 32'(frame_error), 32'h1);
        chk("double_err_count", 32'(err_count), 32'd6);
        tick();
        chk("double_fe_count", 32'(fe_cnt - fe_snap), 32'd1);
        shoot = 1'b0;
        repeat (4) tick();

        // Error counter saturation
        for (int i = 0; i < 260; i++) send_byte(8'h00, 1'b1);
        chk("sat_err_count", 32'(err_count), 32'd255);

        // Reset mid-frame
        send_byte(8'h12, 1'b0);
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        chk("mid_rst_staged", 32'(staged_index), 32'h000);
        chk("mid_rst_active", 32'(active_index), 32'h000);
        chk("mid_rst_valid", 32'(active_valid), 32'h0);
        chk("mid_rst_err", 32'(err_count), 32'h00);
        snap();
        send_byte(8'h31, 1'b0);
        tick();
        chk("mid_rst_lo_only_fv", 32'(fv_cnt - fv_snap), 32'd0);
        chk("mid_rst_lo_only_staged", 32'(staged_index), 32'h000);
        send_byte(8'hF1, 1'b0);
        chk("mid_rst_as_hi_index", 32'(staged_index), 32'h31F);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
